// File: rtl/pio_core_if.sv
// Host command bus of the PIO core: one-cycle action/index/din command and the registered read-back word.
interface pio_core_if;
  logic [2:0]  action;
  logic [4:0]  index;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output action, output index, output din, input dout);
  modport slave  (input action, input index, input din, output dout);
endinterface

// File: rtl/pio_core.sv
// Single RP2040-style programmable-I/O state machine with imem, X/Y/ISR/OSR, TX/RX FIFOs and clock divider.
// Optional build macro PIO_AUTOPUSH_PULL_EN adds automatic ISR push / OSR refill on 32-bit boundaries.
module pio_core #(
  parameter int FIFO_DEPTH = 4,
  parameter int IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] div,
  pio_core_if.slave   bus,
  output logic [31:0] pins
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic [15:0] imem [IMEM_WORDS];
  logic [31:0] tx_mem [FIFO_DEPTH];
  logic [31:0] rx_mem [FIFO_DEPTH];

  logic [4:0]  pc_q, pc_d, delay_q, delay_d, wrap_bot_q, wrap_bot_d, wrap_top_q, wrap_top_d;
  logic        en_q, en_d;
  logic [31:0] x_q, x_d, y_q, y_d, isr_q, isr_d, osr_q, osr_d, pins_q, pins_d, dout_q, dout_d;
  logic [5:0]  isr_cnt_q, isr_cnt_d, osr_cnt_q, osr_cnt_d;
  logic [23:0] divcnt_q, divcnt_d;
  logic [PW-1:0] tx_rd_q, tx_wr_q, rx_rd_q, rx_wr_q;
  logic [LW-1:0] tx_cnt_q, rx_cnt_q;

  logic        tick, stall, cond, rx_room, host_tx_push, host_rx_pop, sm_tx_pop, sm_rx_push;
  logic [15:0] instr;
  logic [5:0]  n6, icnt, ocnt;
  logic [4:0]  pc_adv, pc_nxt;
  logic [31:0] mask, val, isr_new, osr_src, tx_head, rx_wdata;

  function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [5:0] b);
    logic [6:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 7'd32) ? 6'd32 : s[5:0];
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  assign host_tx_push = (bus.action == 3'd5) && (tx_cnt_q != LW'(FIFO_DEPTH));
  assign host_rx_pop  = (bus.action == 3'd6) && (rx_cnt_q != '0);
  assign pins         = pins_q;
  assign bus.dout     = dout_q;

  // Divider: count only while enabled; a host restart re-phases it.
  always_comb begin
    tick     = 1'b0;
    divcnt_d = divcnt_q;
    if (!en_q) divcnt_d = '0;
    else if (div < 24'd2 || divcnt_q >= div - 24'd1) begin
      tick     = 1'b1;
      divcnt_d = '0;
    end else divcnt_d = divcnt_q + 24'd1;
    if (bus.action == 3'd4) divcnt_d = '0;
  end

  always_comb begin
    instr   = imem[pc_q];
    n6      = {(instr[4:0] == 5'd0), instr[4:0]};   // operand 0 encodes 32
    mask    = ~(32'hFFFF_FFFF << n6);
    pc_adv  = (pc_q == wrap_top_q) ? wrap_bot_q : pc_q + 5'd1;
    rx_room = (rx_cnt_q != LW'(FIFO_DEPTH)) || host_rx_pop;
    tx_head = tx_mem[tx_rd_q];
    pc_d = pc_q; delay_d = delay_q; x_d = x_q; y_d = y_q; pins_d = pins_q;
    isr_d = isr_q; osr_d = osr_q; isr_cnt_d = isr_cnt_q; osr_cnt_d = osr_cnt_q;
    en_d = en_q; wrap_bot_d = wrap_bot_q; wrap_top_d = wrap_top_q; dout_d = dout_q;
    sm_tx_pop = 1'b0; sm_rx_push = 1'b0; rx_wdata = isr_q;
    stall = 1'b0; pc_nxt = pc_adv; val = '0; cond = 1'b0;
    osr_src = osr_q; ocnt = osr_cnt_q; isr_new = '0; icnt = '0;

    if (en_q && tick) begin
      if (delay_q != 5'd0) delay_d = delay_q - 5'd1;
      else begin
        case (instr[15:13])
          3'b000: begin
            case (instr[7:5])
              3'd0:    cond = 1'b1;
              3'd1:    cond = (x_q == '0);
              3'd2:    cond = (x_q != '0);
              3'd3:    cond = (y_q == '0);
              3'd4:    cond = (y_q != '0);
              3'd5:    cond = (x_q != y_q);
              3'd6:    cond = pins_q[0];
              default: cond = (osr_cnt_q < 6'd32);
            endcase
            if (instr[7:5] == 3'd2) x_d = x_q - 32'd1;
            if (instr[7:5] == 3'd4) y_d = y_q - 32'd1;
            if (cond) pc_nxt = instr[4:0];
          end
          3'b010: begin
            case (instr[7:5])
              3'd0: val = pins_q;  3'd1: val = x_q;  3'd2: val = y_q;
              3'd6: val = isr_q;   3'd7: val = osr_q;
              default: val = '0;
            endcase
            isr_new = (isr_q << n6) | (val & mask);
            icnt    = sat_add(isr_cnt_q, n6);
`ifdef PIO_AUTOPUSH_PULL_EN
            if (icnt == 6'd32) begin
              if (rx_room) begin
                sm_rx_push = 1'b1; rx_wdata = isr_new; isr_new = '0; icnt = '0;
              end else stall = 1'b1;
            end
`endif
            if (!stall) begin isr_d = isr_new; isr_cnt_d = icnt; end
          end
          3'b011: begin
`ifdef PIO_AUTOPUSH_PULL_EN
            if (osr_cnt_q == 6'd32) begin
              if (tx_cnt_q != '0) begin
                osr_src = tx_head; ocnt = '0; sm_tx_pop = 1'b1;
              end else stall = 1'b1;
            end
`endif
            val = osr_src & mask;
            if (!stall) begin
              osr_d     = osr_src >> n6;
              osr_cnt_d = sat_add(ocnt, n6);
              case (instr[7:5])
                3'd0: pins_d = val;  3'd1: x_d = val;  3'd2: y_d = val;
                3'd5: pc_nxt = val[4:0];
                3'd6: isr_d  = val;
                default: ;
              endcase
            end
          end
          3'b100: begin
            if (!instr[7]) begin
              if (rx_room) begin sm_rx_push = 1'b1; isr_d = '0; isr_cnt_d = '0; end
              else if (instr[5]) stall = 1'b1;
              else begin isr_d = '0; isr_cnt_d = '0; end
            end else begin
              if (tx_cnt_q != '0) begin osr_d = tx_head; osr_cnt_d = '0; sm_tx_pop = 1'b1; end
              else if (instr[5]) stall = 1'b1;
              else begin osr_d = x_q; osr_cnt_d = '0; end
            end
          end
          3'b101: begin
            case (instr[2:0])
              3'd0: val = pins_q;  3'd1: val = x_q;  3'd2: val = y_q;
              3'd5: val = (tx_cnt_q == '0) ? 32'hFFFF_FFFF : 32'd0;
              3'd6: val = isr_q;   3'd7: val = osr_q;
              default: val = '0;
            endcase
            case (instr[4:3])
              2'd1:    val = ~val;
              2'd2:    val = bit_rev(val);
              default: ;
            endcase
            case (instr[7:5])
              3'd0: pins_d = val;  3'd1: x_d = val;  3'd2: y_d = val;
              3'd5: pc_nxt = val[4:0];
              3'd6: begin isr_d = val; isr_cnt_d = '0; end
              3'd7: begin osr_d = val; osr_cnt_d = '0; end
              default: ;
            endcase
          end
          3'b111: begin
            case (instr[7:5])
              3'd0: pins_d = {pins_q[31:5], instr[4:0]};
              3'd1: x_d    = {27'd0, instr[4:0]};
              3'd2: y_d    = {27'd0, instr[4:0]};
              default: ;
            endcase
          end
          default: ;
        endcase
        if (!stall) begin pc_d = pc_nxt; delay_d = instr[12:8]; end
      end
    end

    // Host commands take priority over the state machine's own updates.
    case (bus.action)
      3'd2: begin wrap_bot_d = bus.din[4:0]; wrap_top_d = bus.din[12:8]; end
      3'd3: en_d = bus.din[0];
      3'd4: begin pc_d = bus.index; isr_cnt_d = '0; osr_cnt_d = '0; end
      3'd6: dout_d = (rx_cnt_q != '0) ? rx_mem[rx_rd_q] : 32'd0;
      3'd7: dout_d = {15'b0, en_q, 1'b0, 3'(rx_cnt_q), 1'b0, 3'(tx_cnt_q), 3'b0, pc_q};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.action == 3'd1) imem[bus.index] <= bus.din[15:0];
    if (host_tx_push) tx_mem[tx_wr_q] <= bus.din;
    if (sm_rx_push)   rx_mem[rx_wr_q] <= rx_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0; delay_q <= '0; wrap_bot_q <= 5'd0; wrap_top_q <= 5'd31; en_q <= 1'b0;
      x_q <= '0; y_q <= '0; isr_q <= '0; osr_q <= '0; pins_q <= '0; dout_q <= '0;
      isr_cnt_q <= '0; osr_cnt_q <= '0; divcnt_q <= '0;
      tx_rd_q <= '0; tx_wr_q <= '0; tx_cnt_q <= '0;
      rx_rd_q <= '0; rx_wr_q <= '0; rx_cnt_q <= '0;
    end else begin
      pc_q <= pc_d; delay_q <= delay_d; wrap_bot_q <= wrap_bot_d; wrap_top_q <= wrap_top_d; en_q <= en_d;
      x_q <= x_d; y_q <= y_d; isr_q <= isr_d; osr_q <= osr_d; pins_q <= pins_d; dout_q <= dout_d;
      isr_cnt_q <= isr_cnt_d; osr_cnt_q <= osr_cnt_d; divcnt_q <= divcnt_d;
      tx_wr_q  <= tx_wr_q + PW'(host_tx_push);
      tx_rd_q  <= tx_rd_q + PW'(sm_tx_pop);
      tx_cnt_q <= tx_cnt_q + LW'(host_tx_push) - LW'(sm_tx_pop);
      rx_wr_q  <= rx_wr_q + PW'(sm_rx_push);
      rx_rd_q  <= rx_rd_q + PW'(host_rx_pop);
      rx_cnt_q <= rx_cnt_q + LW'(sm_rx_push) - LW'(host_rx_pop);
    end
  end
endmodule

// File: tb/tb_pio_core.sv
// Directed bench for pio_core: idle, SET, divider timing, MOV, echo/stall/FIFO limits and async reset.
module tb_pio_core;
  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] div;
  logic [31:0] pins;
  int n_cmp = 0;
  int n_bad = 0;

  pio_core_if bus();
  pio_core dut (.clk(clk), .reset(reset), .div(div), .bus(bus), .pins(pins));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] a, input logic [4:0] idx, input logic [31:0] d);
    @(negedge clk);
    bus.action = a; bus.index = idx; bus.din = d;
    @(negedge clk);
    bus.action = 3'd0; bus.index = 5'd0; bus.din = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic status(input string tag, input logic [31:0] exp);
    cmd(3'd7, 5'd0, 32'd0);
    check(tag, bus.dout, exp);
  endtask

  task automatic pop(input string tag, input logic [31:0] exp);
    cmd(3'd6, 5'd0, 32'd0);
    check(tag, bus.dout, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
  endtask

  logic [31:0] echo_vals [5] = '{32'h0123_4567, 32'h89AB_CDEF, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h5555_5555};

  initial begin
    reset = 1'b1; div = 24'd2;
    bus.action = 3'd0; bus.index = 5'd0; bus.din = 32'd0;
    do_reset();
    check("reset_dout", bus.dout, 32'd0);
    check("reset_pins", pins, 32'd0);
    idle(100);
    check("idle_pins", pins, 32'd0);
    status("idle_status", 32'h0000_0000);

    // SET pins then spin on JMP 1
    div = 24'd1;
    cmd(3'd1, 5'd0, 32'h0000_E015);
    cmd(3'd1, 5'd1, 32'h0000_0001);
    cmd(3'd3, 5'd0, 32'd1);
    idle(1);
    check("set_pins", pins, 32'h0000_0015);
    idle(5);
    status("set_status_pc1", 32'h0001_0001);

    // Divider 4: pins change on the 4th edge after enable
    do_reset();
    div = 24'd4;
    cmd(3'd1, 5'd0, 32'h0000_E00A);
    cmd(3'd3, 5'd0, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      idle(1);
      check($sformatf("div_wait%0d", k), pins, 32'd0);
    end
    idle(1);
    check("div_pins", pins, 32'h0000_000A);

    // SET X 5; MOV PINS ~X; MOV PINS ::X; spin
    do_reset();
    div = 24'd1;
    cmd(3'd1, 5'd0, 32'h0000_E025);
    cmd(3'd1, 5'd1, 32'h0000_A009);
    cmd(3'd1, 5'd2, 32'h0000_A011);
    cmd(3'd1, 5'd3, 32'h0000_0003);
    cmd(3'd3, 5'd0, 32'd1);
    idle(1);
    check("mov_after_setx", pins, 32'd0);
    idle(1);
    check("mov_invert", pins, 32'hFFFF_FFFA);
    idle(1);
    check("mov_reverse", pins, 32'hA000_0000);
    async_reset_pulse();
    check("async_pins", pins, 32'd0);
    idle(2);
    reset = 1'b0;
    status("post_reset_en", 32'h0000_0000);

    // Echo: PULL blk; OUT X 32; IN X 32; PUSH blk; wrap 3->0
    cmd(3'd1, 5'd0, 32'h0000_80A0);
    cmd(3'd1, 5'd1, 32'h0000_6020);
    cmd(3'd1, 5'd2, 32'h0000_4020);
    cmd(3'd1, 5'd3, 32'h0000_8020);
    cmd(3'd2, 5'd0, 32'h0000_0300);
    cmd(3'd3, 5'd0, 32'd1);
    idle(10);
    status("stall_pc0", 32'h0001_0000);
    cmd(3'd5, 5'd0, 32'hDEAD_BEEF);
    idle(20);
    status("echo_status", 32'h0001_1000);
    pop("echo_pop", 32'hDEAD_BEEF);
    status("echo_drained", 32'h0001_0000);
    pop("empty_pop", 32'd0);

    // Freeze, overfill TX (5th dropped), then release and drain
    cmd(3'd3, 5'd0, 32'd0);
    for (int k = 0; k < 5; k++) cmd(3'd5, 5'd0, echo_vals[k]);
    status("tx_full", 32'h0000_0400);
    cmd(3'd3, 5'd0, 32'd1);
    idle(40);
    status("rx_full", 32'h0001_4000);
    for (int k = 0; k < 4; k++) pop($sformatf("echo_pop%0d", k), echo_vals[k]);
    status("all_drained", 32'h0001_0000);
    pop("dropped_word", 32'd0);

    cmd(3'd5, 5'd0, 32'hCAFE_F00D);
    idle(10);
    pop("pre_reset_pop", 32'hCAFE_F00D);
    async_reset_pulse();
    check("async_dout", bus.dout, 32'd0);
    check("async_pins2", pins, 32'd0);
    idle(2);
    reset = 1'b0;
    status("final_status", 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
